// File: rtl/ecc_pkg.sv
// Shared constants and types for the ECC post-processing stages.
package ecc_pkg;

  // Default coordinate / modulus width and its one-bit-wider companion,
  // used for sums that can momentarily reach 2P.
  localparam int DATA_WIDTH_DEF = 256;
  localparam int EXT_WIDTH_DEF  = DATA_WIDTH_DEF + 1;

  // SM2 field prime.
  localparam logic [DATA_WIDTH_DEF-1:0] SM2_P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  // Jacobian-to-affine sequencer states.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INV  = 3'd1,
    S_SQ   = 3'd2,
    S_MX   = 3'd3,
    S_CU   = 3'd4,
    S_MY   = 3'd5,
    S_DONE = 3'd6
  } jac2aff_state_e;

endpackage

// File: rtl/mod_inv_bin.sv
// Binary extended-Euclid modular inverter: result = a^-1 mod p, one
// reduction step per clock. start loads the operands; done is high for
// exactly the one cycle in which result is valid, and the unit goes idle
// on the following edge. a must be non-zero and below p; p must be odd.
module mod_inv_bin
  import ecc_pkg::*;
#(
  parameter int W = DATA_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] p,
  output logic         done,
  output logic [W-1:0] result
);

  logic         busy;
  logic [W-1:0] u, v, x1, x2;
  logic [W-1:0] u_nxt, v_nxt, x1_nxt, x2_nxt;

  // x/2 mod m: odd values are made even by adding m first (needs W+1 bits).
  function automatic logic [W-1:0] halve_mod(input logic [W-1:0] x,
                                             input logic [W-1:0] m);
    logic [W:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return W'(s >> 1);
  endfunction

  // (x - y) mod m for x, y < m.
  function automatic logic [W-1:0] sub_mod(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic [W-1:0] m);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) d = d + {1'b0, m};
    return W'(d);
  endfunction

  assign done   = busy & ((u == W'(1)) | (v == W'(1)));
  assign result = (u == W'(1)) ? x1 : x2;

  // One reduction step: halve whichever of u/v is even, else subtract.
  always_comb begin
    u_nxt  = u;
    v_nxt  = v;
    x1_nxt = x1;
    x2_nxt = x2;
    if (!u[0]) begin
      u_nxt  = u >> 1;
      x1_nxt = halve_mod(x1, p);
    end else if (!v[0]) begin
      v_nxt  = v >> 1;
      x2_nxt = halve_mod(x2, p);
    end else if (u >= v) begin
      u_nxt  = u - v;
      x1_nxt = sub_mod(x1, x2, p);
    end else begin
      v_nxt  = v - u;
      x2_nxt = sub_mod(x2, x1, p);
    end
  end

  // Operand load on start, iterate while busy, release after done.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      u    <= '0;
      v    <= '0;
      x1   <= '0;
      x2   <= '0;
    end else if (start) begin
      busy <= 1'b1;
      u    <= a;
      v    <= p;
      x1   <= W'(1);
      x2   <= '0;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
      end else begin
        u  <= u_nxt;
        v  <= v_nxt;
        x1 <= x1_nxt;
        x2 <= x2_nxt;
      end
    end
  end

endmodule

// File: rtl/jac2aff.sv
// Jacobian (X, Y, Z) to affine (X/Z^2, Y/Z^3) converter over GF(P).
// Handshake: a job is taken on any posedge where in_valid & in_ready; in_ready
// is high only in IDLE, so in_valid while busy is ignored. out_valid pulses
// for one cycle (the first IDLE cycle) with Rx/Ry/inf, which then hold until
// the next result or reset.
module jac2aff
  import ecc_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] P          = DATA_WIDTH'(SM2_P)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] X,
  input  logic [DATA_WIDTH-1:0] Y,
  input  logic [DATA_WIDTH-1:0] Z,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] Rx,
  output logic [DATA_WIDTH-1:0] Ry,
  output logic                  inf,
  output jac2aff_state_e        state_dbg
);

  localparam int         W     = DATA_WIDTH;
  localparam int         CW    = (W > 1) ? $clog2(W) : 1;
  localparam logic [W:0] P_EXT = {1'b0, P};

  jac2aff_state_e state, state_nxt;

  logic          accept, z_zero, inv_start, inv_done;
  logic [W-1:0]  inv_result;
  logic [W-1:0]  x_q, y_q, zinv_q, t_q, rx_int, ry_int, acc_q;
  logic          inf_q;
  logic [CW-1:0] bit_q;
  logic          mul_active, mul_last;
  logic [W-1:0]  mul_a, mul_b, acc_dbl, acc_nxt;
  logic [W:0]    dbl, sum;

  assign in_ready   = (state == S_IDLE);
  assign state_dbg  = state;
  assign accept     = in_valid & in_ready;
  assign z_zero     = (Z == '0);
  assign inv_start  = accept & ~z_zero;
  assign mul_active = (state == S_SQ) || (state == S_MX) ||
                      (state == S_CU) || (state == S_MY);
  assign mul_last   = (bit_q == '0);

  mod_inv_bin #(.W(W)) u_inv (
    .clk    (clk),
    .rst    (rst),
    .start  (inv_start),
    .a      (Z),
    .p      (P),
    .done   (inv_done),
    .result (inv_result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Sequencing: inverse, then Zinv^2, X*t, t*Zinv, Y*t, each multiply W cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = z_zero ? S_DONE : S_INV;
      S_INV:   if (inv_done) state_nxt = S_SQ;
      S_SQ:    if (mul_last) state_nxt = S_MX;
      S_MX:    if (mul_last) state_nxt = S_CU;
      S_CU:    if (mul_last) state_nxt = S_MY;
      S_MY:    if (mul_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand select for the single shared multiplier.
  always_comb begin
    mul_a = zinv_q;
    mul_b = zinv_q;
    case (state)
      S_MX:    begin mul_a = x_q; mul_b = t_q;    end
      S_CU:    begin mul_a = t_q; mul_b = zinv_q; end
      S_MY:    begin mul_a = y_q; mul_b = t_q;    end
      default: begin mul_a = zinv_q; mul_b = zinv_q; end
    endcase
  end

  // One MSB-first multiply step: acc = 2*acc (+a), each reduced by one subtract.
  always_comb begin
    dbl     = {acc_q, 1'b0};
    acc_dbl = (dbl >= P_EXT) ? W'(dbl - P_EXT) : W'(dbl);
    sum     = {1'b0, acc_dbl} + {1'b0, mul_a};
    acc_nxt = acc_dbl;
    if (mul_b[bit_q]) acc_nxt = (sum >= P_EXT) ? W'(sum - P_EXT) : W'(sum);
  end

  // Datapath registers and the registered result interface.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      zinv_q    <= '0;
      t_q       <= '0;
      rx_int    <= '0;
      ry_int    <= '0;
      inf_q     <= 1'b0;
      acc_q     <= '0;
      bit_q     <= CW'(W - 1);
      out_valid <= 1'b0;
      Rx        <= '0;
      Ry        <= '0;
      inf       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        x_q    <= X;
        y_q    <= Y;
        rx_int <= '0;
        ry_int <= '0;
        inf_q  <= z_zero;
      end
      if ((state == S_INV) && inv_done) zinv_q <= inv_result;
      if (mul_active) begin
        if (mul_last) begin
          acc_q <= '0;
          bit_q <= CW'(W - 1);
          case (state)
            S_MX:    rx_int <= acc_nxt;
            S_MY:    ry_int <= acc_nxt;
            default: t_q    <= acc_nxt;
          endcase
        end else begin
          acc_q <= acc_nxt;
          bit_q <= bit_q - CW'(1);
        end
      end
      if (state == S_DONE) begin
        out_valid <= 1'b1;
        Rx        <= rx_int;
        Ry        <= ry_int;
        inf       <= inf_q;
      end
    end
  end

endmodule

// File: tb/tb_jac2aff.sv
// Directed bench for jac2aff: a W=8/P=23 instance for the hand-computed
// vectors and a default SM2 instance for the generator-point case.
module tb_jac2aff;
  import ecc_pkg::*;

  localparam int             SW    = 8;
  localparam logic [SW-1:0]  SP    = 8'd23;
  localparam int             BW    = 256;
  localparam int             EXP_W = 2 * SW + 1;
  localparam logic [BW-1:0]  GX =
    256'h32C4AE2C_1F198119_5F990446_6A39C994_8FE30BBF_F2660BE1_715A4589_334C74C7;
  localparam logic [BW-1:0]  GY =
    256'hBC3736A2_F4F6779C_59BDCEE3_6B692153_D0A9877C_C62A4740_02DF32E5_2139F0A0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- small instance ----------------
  logic           s_in_valid = 1'b0;
  logic           s_in_ready;
  logic [SW-1:0]  s_x = '0, s_y = '0, s_z = '0;
  logic           s_out_valid;
  logic [SW-1:0]  s_rx, s_ry;
  logic           s_inf;
  jac2aff_state_e s_state;

  jac2aff #(.DATA_WIDTH(SW), .P(SP)) u_small (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .X         (s_x),
    .Y         (s_y),
    .Z         (s_z),
    .out_valid (s_out_valid),
    .Rx        (s_rx),
    .Ry        (s_ry),
    .inf       (s_inf),
    .state_dbg (s_state)
  );

  // ---------------- SM2 instance ----------------
  logic           b_in_valid = 1'b0;
  logic           b_in_ready;
  logic [BW-1:0]  b_x = '0, b_y = '0, b_z = '0;
  logic           b_out_valid;
  logic [BW-1:0]  b_rx, b_ry;
  logic           b_inf;
  jac2aff_state_e b_state;

  jac2aff u_big (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .X         (b_x),
    .Y         (b_y),
    .Z         (b_z),
    .out_valid (b_out_valid),
    .Rx        (b_rx),
    .Ry        (b_ry),
    .inf       (b_inf),
    .state_dbg (b_state)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [BW-1:0] obs,
                       input logic [BW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard: {inf, Ry, Rx} ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] sb_e;

  always @(negedge clk) begin
    if (!rst && s_out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", s_out_valid, 0);
      end else begin
        sb_e = exp_q.pop_front();
        check("rx",  s_rx,  sb_e[SW-1:0]);
        check("ry",  s_ry,  sb_e[2*SW-1:SW]);
        check("inf", s_inf, sb_e[2*SW]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [SW-1:0] x, input logic [SW-1:0] y,
                      input logic [SW-1:0] z);
    int n;
    n = 0;
    @(negedge clk);
    while (!s_in_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_before_send", s_in_ready, 1);
    s_x = x;
    s_y = y;
    s_z = z;
    s_in_valid = 1'b1;
    @(posedge clk);
    #1 s_in_valid = 1'b0;
    check("in_ready_drop_on_accept", s_in_ready, 0);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!s_out_valid && lat < 4000);
    check("out_valid_seen", s_out_valid, 1);
    check("in_ready_with_out_valid", s_in_ready, 1);
    @(negedge clk);
    check("out_valid_one_cycle", s_out_valid, 0);
  endtask

  task automatic job(input logic [SW-1:0] x, input logic [SW-1:0] y,
                     input logic [SW-1:0] z, input logic [SW-1:0] erx,
                     input logic [SW-1:0] ery, input logic einf,
                     output int lat);
    exp_q.push_back({einf, ery, erx});
    send(x, y, z);
    wait_out(lat);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  s_in_ready,  1);
    check("rst_out_valid", s_out_valid, 0);
    check("rst_rx",        s_rx,        0);
    check("rst_ry",        s_ry,        0);
    check("rst_inf",       s_inf,       0);
    check("rst_state",     s_state,     S_IDLE);
    check("rst_big_ready", b_in_ready,  1);
    rst = 1'b0;

    // SM2 generator with Z=1 must come back unchanged.
    @(negedge clk);
    b_x = GX;
    b_y = GY;
    b_z = 256'd1;
    b_in_valid = 1'b1;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!b_out_valid && lat < 3000);
    check("g_out_valid", b_out_valid, 1);
    check("g_rx",        b_rx,        GX);
    check("g_ry",        b_ry,        GY);
    check("g_inf",       b_inf,       0);
    check("g_lat_max",   lat <= 1542, 1);
    check("g_lat_full",  lat >= 4 * BW, 1);

    // Hand-computed P=23 vectors.
    job(8'd5, 8'd4, 8'd2, 8'h07, 8'h0C, 1'b0, lat);
    check("z2_lat_max", lat <= 2 * SW + 4 * SW + 6, 1);
    job(8'd5, 8'd4, 8'd22, 8'h05, 8'h13, 1'b0, lat);
    job(8'd9, 8'd17, 8'd0, 8'h00, 8'h00, 1'b1, lat);
    check("z0_lat", lat, 2);
    job(8'd22, 8'd22, 8'd5, 8'h0B, 8'h10, 1'b0, lat);
    repeat (5) @(negedge clk);
    check("hold_rx", s_rx, 8'h0B);
    check("hold_ry", s_ry, 8'h10);
    job(8'd1, 8'd1, 8'd1, 8'h01, 8'h01, 1'b0, lat);

    // in_valid held through a busy job with a different Z.
    exp_q.push_back({1'b0, 8'h0C, 8'h07});
    exp_q.push_back({1'b0, 8'h13, 8'h05});
    @(negedge clk);
    s_x = 8'd5;
    s_y = 8'd4;
    s_z = 8'd2;
    s_in_valid = 1'b1;
    @(posedge clk);
    #1 s_z = 8'd22;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_out_valid && n < 4000);
    check("busy_first_out_valid", s_out_valid, 1);
    @(posedge clk);
    #1 s_in_valid = 1'b0;
    check("busy_second_accepted", s_in_ready, 0);
    wait_out(lat);

    // Reset in the middle of the X multiply aborts the job.
    send(8'd5, 8'd4, 8'd2);
    n = 0;
    while (s_state != S_MX && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_mx", s_state == S_MX, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out_valid", s_out_valid, 0);
    check("abort_rx",        s_rx,        0);
    check("abort_ry",        s_ry,        0);
    check("abort_inf",       s_inf,       0);
    check("abort_in_ready",  s_in_ready,  1);
    check("abort_state",     s_state,     S_IDLE);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    job(8'd5, 8'd4, 8'd2, 8'h07, 8'h0C, 1'b0, lat);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
